way_controller: RTL and testbench

Initiator side of the way storage interface for the L2 cache model. Accepts line-granular read and write requests, reads all four ways of the addressed set, compares tags, and returns hit/miss with data. Write requests update the hitting way or allocate a victim using per-set tree pseudo-LRU. After reset, it walks every set to invalidate all ways before accepting requests.

---
 rtl/way_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_way_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/way_controller.sv
// ---------------------------------------------------------------------------
// way_controller
//
// Initiator side of the L2 way storage interface. After reset it walks every
// set, invalidating all four ways and zeroing that set's pseudo-LRU bits.
// It then serves one line request at a time: read the set, compare the four
// tags, answer hit/miss (with data on a read hit), and on a write either
// overwrite the hitting way or allocate a victim (lowest invalid way, else
// the tree-PLRU way).
//
// Ports
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = write/fill line, 0 = read
//   req_addr              {tag, index} line address
//   req_data              write data
//   rsp_valid             one-cycle response pulse
//   rsp_hit/way/data      response fields, held between pulses
//   way_index             set addressed at the way array
//   way_rd_en             read strobe, array answers on the next cycle
//   way_tag_in/valid_in/data_in   four-way read data from the array
//   way_wr_en             per-way write enable (all ones while clearing)
//   way_wr_tag/data/valid write payload
//
// Request timeline (accept at T): read strobe T+1, compare T+2, response and
// any way write T+3, ready again at T+4.
// ---------------------------------------------------------------------------
module way_controller #(
   parameter int indexBits = 14,
   parameter int tagBits   = 14,
   parameter int lineSize  = 512
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [tagBits+indexBits-1:0]  req_addr,
   input  logic [lineSize-1:0]           req_data,
   output logic                          rsp_valid,
   output logic                          rsp_hit,
   output logic [1:0]                    rsp_way,
   output logic [lineSize-1:0]           rsp_data,
   output logic [indexBits-1:0]          way_index,
   output logic                          way_rd_en,
   input  logic [4*tagBits-1:0]          way_tag_in,
   input  logic [3:0]                    way_valid_in,
   input  logic [4*lineSize-1:0]         way_data_in,
   output logic [3:0]                    way_wr_en,
   output logic [tagBits-1:0]            way_wr_tag,
   output logic [lineSize-1:0]           way_wr_data,
   output logic                          way_wr_valid
);

   localparam int numSets = 1 << indexBits;

   typedef enum logic [2:0] {CLEAR, IDLE, READ, COMPARE, RESP} state_t;

   state_t                state_reg;
   logic [indexBits-1:0]  clr_idx_reg;
   logic                  write_reg;
   logic [tagBits-1:0]    tag_reg;
   logic [indexBits-1:0]  idx_reg;
   logic [lineSize-1:0]   data_reg;
   logic                  rsp_hit_reg;
   logic [1:0]            rsp_way_reg;
   logic [lineSize-1:0]   rsp_data_reg;

   // Per-set PLRU bits {b2,b1,b0}, read one cycle ahead of the compare.
   logic [2:0]            plru_mem [numSets];
   logic [2:0]            plru_rd_reg;
   logic [2:0]            plru_next;

   logic [tagBits-1:0]    way_tag  [4];
   logic [lineSize-1:0]   way_data [4];
   logic [3:0]            match;

   logic                  hit_any;
   logic [1:0]            hit_way;
   logic [1:0]            plru_way;
   logic [1:0]            victim_way;
   logic [1:0]            sel_way;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_way
         assign way_tag[gi]  = way_tag_in[gi*tagBits +: tagBits];
         assign way_data[gi] = way_data_in[gi*lineSize +: lineSize];
         assign match[gi]    = way_valid_in[gi] && (way_tag[gi] == tag_reg);
      end
   endgenerate

   function automatic logic [1:0] lowest_set(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Tag compare and victim choice, consumed in COMPARE.
   always_comb begin
      hit_any  = |match;
      hit_way  = lowest_set(match);
      // b0 picks the pair, then b1 (pair 0/1) or b2 (pair 2/3) picks the way.
      plru_way = plru_rd_reg[0] ? (plru_rd_reg[2] ? 2'd3 : 2'd2)
                                : (plru_rd_reg[1] ? 2'd1 : 2'd0);
      if (!(&way_valid_in))
         victim_way = lowest_set(~way_valid_in);
      else
         victim_way = plru_way;
      sel_way = hit_any ? hit_way : victim_way;
   end

   // Point the tree away from the way just touched; untouched subtree keeps its bit.
   always_comb begin
      plru_next = plru_rd_reg;
      case (rsp_way_reg)
         2'd0:    plru_next = {plru_rd_reg[2], 1'b1, 1'b1};
         2'd1:    plru_next = {plru_rd_reg[2], 1'b0, 1'b1};
         2'd2:    plru_next = {1'b1, plru_rd_reg[1], 1'b0};
         default: plru_next = {1'b0, plru_rd_reg[1], 1'b0};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= CLEAR;
         clr_idx_reg  <= '0;
         write_reg    <= 1'b0;
         tag_reg      <= '0;
         idx_reg      <= '0;
         data_reg     <= '0;
         rsp_hit_reg  <= 1'b0;
         rsp_way_reg  <= 2'd0;
         rsp_data_reg <= '0;
      end else begin
         case (state_reg)
            CLEAR: begin
               clr_idx_reg <= clr_idx_reg + 1'b1;
               if (&clr_idx_reg)
                  state_reg <= IDLE;
            end
            IDLE: begin
               if (req_valid) begin
                  write_reg <= req_write;
                  tag_reg   <= req_addr[tagBits+indexBits-1:indexBits];
                  idx_reg   <= req_addr[indexBits-1:0];
                  data_reg  <= req_data;
                  state_reg <= READ;
               end
            end
            READ: begin
               state_reg <= COMPARE;
            end
            COMPARE: begin
               rsp_hit_reg  <= hit_any;
               rsp_way_reg  <= sel_way;
               rsp_data_reg <= (!write_reg && hit_any) ? way_data[hit_way] : '0;
               state_reg    <= RESP;
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= CLEAR;
            end
         endcase
      end
   end

   // PLRU storage kept free of reset so it maps onto block RAM; the clear walk
   // is what initialises it. A read miss leaves the set's bits untouched.
   always_ff @(posedge clk) begin
      if (state_reg == READ)
         plru_rd_reg <= plru_mem[idx_reg];
      if (!reset) begin
         if (state_reg == CLEAR)
            plru_mem[clr_idx_reg] <= 3'b000;
         else if (state_reg == RESP && (write_reg || rsp_hit_reg))
            plru_mem[idx_reg] <= plru_next;
      end
   end

   // Outputs decode from registered state only; reset forces every output low
   // even before the first sampling edge, so a reset mid-request cannot leak
   // a response pulse or a way write.
   always_comb begin
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      rsp_hit      = 1'b0;
      rsp_way      = 2'd0;
      rsp_data     = '0;
      way_index    = '0;
      way_rd_en    = 1'b0;
      way_wr_en    = 4'b0000;
      way_wr_tag   = '0;
      way_wr_data  = '0;
      way_wr_valid = 1'b0;
      if (!reset) begin
         rsp_hit   = rsp_hit_reg;
         rsp_way   = rsp_way_reg;
         rsp_data  = rsp_data_reg;
         way_index = (state_reg == CLEAR) ? clr_idx_reg : idx_reg;
         case (state_reg)
            CLEAR:   way_wr_en = 4'b1111;
            IDLE:    req_ready = 1'b1;
            READ:    way_rd_en = 1'b1;
            RESP: begin
               rsp_valid = 1'b1;
               if (write_reg) begin
                  way_wr_en    = 4'b0001 << rsp_way_reg;
                  way_wr_tag   = tag_reg;
                  way_wr_data  = data_reg;
                  way_wr_valid = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_way_controller.sv
module tb_way_controller;

   localparam int IB = 4;
   localparam int TB = 14;
   localparam int LS = 512;
   localparam int NS = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [TB+IB-1:0]  req_addr = '0;
   logic [LS-1:0]     req_data = '0;
   logic              rsp_valid;
   logic              rsp_hit;
   logic [1:0]        rsp_way;
   logic [LS-1:0]     rsp_data;
   logic [IB-1:0]     way_index;
   logic              way_rd_en;
   logic [4*TB-1:0]   way_tag_in;
   logic [3:0]        way_valid_in;
   logic [4*LS-1:0]   way_data_in;
   logic [3:0]        way_wr_en;
   logic [TB-1:0]     way_wr_tag;
   logic [LS-1:0]     way_wr_data;
   logic              way_wr_valid;

   always #5 clk = ~clk;

   way_controller #(.indexBits(IB), .tagBits(TB), .lineSize(LS)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_data(rsp_data),
      .way_index(way_index), .way_rd_en(way_rd_en),
      .way_tag_in(way_tag_in), .way_valid_in(way_valid_in), .way_data_in(way_data_in),
      .way_wr_en(way_wr_en), .way_wr_tag(way_wr_tag), .way_wr_data(way_wr_data),
      .way_wr_valid(way_wr_valid)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [LS-1:0] act, input logic [LS-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Cycle number since reset release (cycle 0 = first cycle with reset low).
   int cyc = 0;
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Way storage array the controller drives; starts full of stale valid lines
   // so a missing clear shows up as a false hit.
   logic [TB-1:0] a_tag   [NS][4];
   logic          a_valid [NS][4];
   logic [LS-1:0] a_data  [NS][4];
   bit            arr_init = 1'b0;

   always @(posedge clk) begin
      if (!arr_init) begin
         for (int s = 0; s < NS; s++)
            for (int w = 0; w < 4; w++) begin
               a_tag[s][w]   <= 14'h12;
               a_valid[s][w] <= 1'b1;
               a_data[s][w]  <= {16{32'hDEAD0000 + 32'(s*4 + w)}};
            end
         arr_init <= 1'b1;
      end else begin
         for (int w = 0; w < 4; w++)
            if (way_wr_en[w]) begin
               a_tag[way_index][w]   <= way_wr_tag;
               a_valid[way_index][w] <= way_wr_valid;
               a_data[way_index][w]  <= way_wr_data;
            end
      end
      if (way_rd_en)
         for (int w = 0; w < 4; w++) begin
            way_tag_in[w*TB +: TB]  <= a_tag[way_index][w];
            way_valid_in[w]         <= a_valid[way_index][w];
            way_data_in[w*LS +: LS] <= a_data[way_index][w];
         end
   end

   // Reference cache: line contents plus the PLRU tree expressed as
   // "which pair is the victim pair" and "which way inside each pair".
   bit            m_valid [NS][4];
   logic [TB-1:0] m_tag   [NS][4];
   logic [LS-1:0] m_data  [NS][4];
   int            m_vpair [NS];   // 0: victim among ways 0/1, 1: among ways 2/3
   int            m_vlow  [NS];   // 0 or 1
   int            m_vhigh [NS];   // 2 or 3

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
         m_vpair[s] = 0;
         m_vlow[s]  = 0;
         m_vhigh[s] = 2;
      end
   endtask

   task automatic model_touch(input int s, input int w);
      if (w < 2) begin
         m_vpair[s] = 1;
         m_vlow[s]  = (w == 0) ? 1 : 0;
      end else begin
         m_vpair[s] = 0;
         m_vhigh[s] = (w == 2) ? 3 : 2;
      end
   endtask

   // Timing expectations and expected response of the request in flight.
   int            ready_at = NS;
   int            acc_cyc = -100;
   logic          exp_write = 1'b0;
   logic          exp_hit = 1'b0;
   int            exp_way = 0;
   bit            exp_way_known = 1'b0;
   logic [LS-1:0] exp_data = '0;
   logic [LS-1:0] exp_wdata = '0;
   logic [TB-1:0] exp_tag = '0;
   logic [IB-1:0] exp_idx = '0;

   task automatic model_access(input logic wr, input logic [TB-1:0] tag,
                               input int s, input logic [LS-1:0] data);
      int hw;
      int w;
      hw = -1;
      for (int i = 3; i >= 0; i--)
         if (m_valid[s][i] && m_tag[s][i] == tag) hw = i;
      exp_write = wr;
      exp_hit   = (hw >= 0);
      if (!wr) begin
         exp_way_known = (hw >= 0);
         exp_way  = (hw >= 0) ? hw : 0;
         exp_data = (hw >= 0) ? m_data[s][hw] : '0;
         if (hw >= 0) model_touch(s, hw);
      end else begin
         w = hw;
         if (w < 0)
            for (int i = 3; i >= 0; i--)
               if (!m_valid[s][i]) w = i;
         if (w < 0)
            w = (m_vpair[s] == 1) ? m_vhigh[s] : m_vlow[s];
         m_valid[s][w] = 1'b1;
         m_tag[s][w]   = tag;
         m_data[s][w]  = data;
         model_touch(s, w);
         exp_way_known = 1'b1;
         exp_way  = w;
         exp_data = '0;
      end
   endtask

   // Observations captured for the directed literal checks.
   int            rsp_count = 0;
   int            rsp_cyc = -1;
   int            clr_seen = 0;
   int            last_acc = -1;
   logic          last_hit = 1'b0;
   logic [1:0]    last_way = 2'd0;
   logic [LS-1:0] last_data = '0;
   logic [3:0]    last_wr_en = 4'd0;
   bit            chk_en = 1'b0;

   // Per-cycle compare against the timing rules and the reference cache.
   always @(negedge clk) begin
      if (chk_en) begin
         if (reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rd_en", way_rd_en, 0);
            chk("rst_wr_en", way_wr_en, 0);
            chk("rst_wr_valid", way_wr_valid, 0);
            chk("rst_index", way_index, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_hit", rsp_hit, 0);
            chk("rst_rsp_way", rsp_way, 0);
            chk("rst_rsp_data", rsp_data, 0);
         end else begin
            chk("req_ready", req_ready, cyc >= ready_at);
            if (cyc < NS) begin
               chk("clr_wr_en", way_wr_en, 4'b1111);
               chk("clr_index", way_index, cyc);
               chk("clr_wr_valid", way_wr_valid, 0);
               chk("clr_wr_tag", way_wr_tag, 0);
               chk("clr_wr_data", way_wr_data, 0);
            end else if (cyc == acc_cyc + 3 && exp_write) begin
               chk("wr_en", way_wr_en, 4'b0001 << exp_way);
               chk("wr_index", way_index, exp_idx);
               chk("wr_tag", way_wr_tag, exp_tag);
               chk("wr_data", way_wr_data, exp_wdata);
               chk("wr_valid", way_wr_valid, 1);
            end else begin
               chk("wr_en_idle", way_wr_en, 0);
            end
            chk("rd_en", way_rd_en, cyc == acc_cyc + 1);
            if (cyc == acc_cyc + 1)
               chk("rd_index", way_index, exp_idx);
            chk("rsp_valid", rsp_valid, cyc == acc_cyc + 3);
            if (cyc == acc_cyc + 3) begin
               chk("rsp_hit", rsp_hit, exp_hit);
               if (exp_way_known) chk("rsp_way", rsp_way, exp_way);
               chk("rsp_data", rsp_data, exp_data);
            end
            if (way_wr_en == 4'b1111) clr_seen++;
            else if (way_wr_en != 4'b0000) last_wr_en = way_wr_en;
            if (rsp_valid) begin
               rsp_count++;
               rsp_cyc   = cyc;
               last_hit  = rsp_hit;
               last_way  = rsp_way;
               last_data = rsp_data;
            end
         end
      end
   end

   // One request; with abort set, reset is raised while the request is in
   // the compare cycle and held for two cycles.
   task automatic do_req(input logic wr, input logic [TB-1:0] tag, input logic [IB-1:0] idx,
                         input logic [LS-1:0] data, input bit abort);
      int waited;
      int t_acc;
      req_write = wr;
      req_addr  = {tag, idx};
      req_data  = data;
      req_valid = 1'b1;
      waited = 0;
      while (1) begin
         @(negedge clk);
         if (req_ready) break;
         waited++;
         if (waited > 60) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1 after %0d cycles", waited);
            req_valid = 1'b0;
            return;
         end
      end
      t_acc = cyc;
      model_access(wr, tag, int'(idx), data);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      exp_idx   = idx;
      exp_tag   = tag;
      exp_wdata = data;
      acc_cyc   = t_acc;
      ready_at  = t_acc + 4;
      last_acc  = t_acc;
      if (abort) begin
         @(posedge clk);
         #1;
         reset    = 1'b1;
         acc_cyc  = -100;
         ready_at = NS;
         clr_seen = 0;
         model_reset();
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;
         $display("txn %0s tag=%0h idx=%0d aborted by reset", wr ? "write" : "read", tag, idx);
         return;
      end
      repeat (3) @(posedge clk);
      #1;
      $display("txn %0s tag=%0h idx=%0d hit=%0b way=%0d", wr ? "write" : "read",
               tag, idx, last_hit, last_way);
   endtask

   function automatic logic [LS-1:0] fill(input logic [31:0] w);
      return {16{w}};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic [LS-1:0] pat_a5;
      pat_a5 = {64{8'hA5}};
      model_reset();
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Read miss right after clear; request raised during the clear walk.
      last_wr_en = 4'd0;
      do_req(1'b0, 14'h12, 4'd3, '0, 1'b0);
      chk("clear_cycles", clr_seen, 16);
      chk("first_accept_cycle", last_acc, 16);
      chk("rsp_latency", rsp_cyc - last_acc, 3);
      chk("miss_hit", last_hit, 0);
      chk("miss_data", last_data, 0);
      chk("miss_no_write", last_wr_en, 0);

      // Fill, then read back.
      last_wr_en = 4'd0;
      do_req(1'b1, 14'h12, 4'd3, pat_a5, 1'b0);
      chk("fill_way", last_way, 0);
      chk("fill_hit", last_hit, 0);
      chk("fill_wr_en", last_wr_en, 4'b0001);
      do_req(1'b0, 14'h12, 4'd3, '0, 1'b0);
      chk("readback_hit", last_hit, 1);
      chk("readback_way", last_way, 0);
      chk("readback_data", last_data, pat_a5);

      // Fill all four ways of set 5, touch way0, then force a PLRU eviction.
      for (int t = 1; t <= 4; t++)
         do_req(1'b1, 14'(t), 4'd5, fill(32'h1000_0000 + 32'(t)), 1'b0);
      chk("fill4_way", last_way, 3);
      do_req(1'b0, 14'h1, 4'd5, '0, 1'b0);
      chk("tag1_hit", last_hit, 1);
      chk("tag1_way", last_way, 0);
      last_wr_en = 4'd0;
      do_req(1'b1, 14'h5, 4'd5, fill(32'h5555_0005), 1'b0);
      chk("model_victim", exp_way, 2);
      chk("victim_way", last_way, 2);
      chk("victim_wr_en", last_wr_en, 4'b0100);
      chk("victim_hit", last_hit, 0);

      // Write hit replaces data in place.
      last_wr_en = 4'd0;
      do_req(1'b1, 14'h2, 4'd5, fill(32'hBEEF_0002), 1'b0);
      chk("whit_wr_en", last_wr_en, 4'b0010);
      chk("whit_hit", last_hit, 1);
      do_req(1'b0, 14'h2, 4'd5, '0, 1'b0);
      chk("whit_read_data", last_data, fill(32'hBEEF_0002));
      do_req(1'b0, 14'h4, 4'd5, '0, 1'b0);
      chk("tag4_way", last_way, 3);

      // Reset during compare: request dropped, clear repeats, contents gone.
      cnt = rsp_count;
      do_req(1'b0, 14'h12, 4'd3, '0, 1'b1);
      chk("abort_no_rsp", rsp_count, cnt);
      do_req(1'b0, 14'h12, 4'd3, '0, 1'b0);
      chk("reclear_cycles", clr_seen, 16);
      chk("reclear_accept", last_acc, 16);
      chk("after_reset_hit_a", last_hit, 0);
      do_req(1'b0, 14'h2, 4'd5, '0, 1'b0);
      chk("after_reset_hit_b", last_hit, 0);
      chk("after_reset_data_b", last_data, 0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
